// File: rtl/ssd_bcd_driver.sv
// Four-digit common-anode seven-segment driver: sequential double-dabble
// binary-to-BCD conversion, time-multiplexed digit scan, optional leading-zero blanking.
module ssd_bcd_driver #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter bit          BLANK_LZ    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [12:0] value,
  output logic [3:0]  anode,
  output logic [6:0]  segments,
  output logic        update
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_LOAD
  } state_e;

  localparam int unsigned   PW         = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);

  state_e        state_q, state_d;
  logic [12:0]   bin_q, bin_d;
  logic [15:0]   bcd_q, bcd_d, bcd_adj;
  logic [3:0]    cnt_q, cnt_d;
  logic [15:0]   disp_q, disp_d;
  logic          update_q, update_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    digit_q, digit_d;
  logic [3:0]    anode_q, anode_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    nibble;
  logic          blank;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b1111111;
    endcase
  endfunction

  // Conversion FSM: value is sampled only in IDLE; the display register is
  // written only in LOAD so a partially converted result is never shown.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d  = state_q;
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    disp_d   = disp_q;
    update_d = 1'b0;
    bcd_adj  = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    case (state_q)
      S_IDLE: begin
        bin_d   = value;
        bcd_d   = '0;
        cnt_d   = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        bcd_d = {bcd_adj[14:0], bin_q[12]};
        bin_d = {bin_q[11:0], 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd12) begin
          state_d  = S_LOAD;
          update_d = 1'b1;
        end
      end
      S_LOAD: begin
        disp_d  = bcd_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    presc_d = presc_q + PW'(1);
    digit_d = digit_q;
    if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      digit_d = digit_q + 2'd1;
    end
  end

  // A digit above 0 is blank when it and every more significant nibble are zero.
  always_comb begin
    nibble = disp_q[4*digit_q +: 4];
    case (digit_q)
      2'd1:    blank = (disp_q[15:4] == '0);
      2'd2:    blank = (disp_q[15:8] == '0);
      2'd3:    blank = (disp_q[15:12] == '0);
      default: blank = 1'b0;
    endcase
    anode_d = ~(4'b0001 << digit_q);
    seg_d   = (BLANK_LZ && blank) ? 7'b1111111 : decode(nibble);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      state_q  <= S_IDLE;
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      disp_q   <= '0;
      update_q <= 1'b0;
      presc_q  <= '0;
      digit_q  <= '0;
      anode_q  <= 4'b1111;
      seg_q    <= 7'b1111111;
    end else begin
      state_q  <= state_d;
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      disp_q   <= disp_d;
      update_q <= update_d;
      presc_q  <= presc_d;
      digit_q  <= digit_d;
      anode_q  <= anode_d;
      seg_q    <= seg_d;
    end
  end

  assign anode    = anode_q;
  assign segments = seg_q;
  assign update   = update_q;

endmodule

// File: tb/tb_ssd_bcd_driver.sv
// Self-checking bench for ssd_bcd_driver: table of values with hand-decoded
// digit patterns, plus reset, scan-timing, mid-conversion change and abort sequences.
module tb_ssd_bcd_driver;

  localparam logic [6:0] BL = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [12:0] value = '0;
  logic [3:0]  anode;
  logic [6:0]  segments;
  logic        update;

  int checks   = 0;
  int failures = 0;
  int cyc_free = 0;
  int base     = 0;

  typedef struct {
    logic [12:0]     val;
    logic [3:0][6:0] segs;  // {digit3, digit2, digit1, digit0}
  } vec_t;

  vec_t vecs [8];

  ssd_bcd_driver #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut (
    .clk      (clk),
    .rst      (rst),
    .value    (value),
    .anode    (anode),
    .segments (segments),
    .update   (update)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_free <= cyc_free + 1;

  // Cycles since reset release: 1 at the first falling edge after the first un-reset rising edge.
  function automatic int n_now();
    return cyc_free - base;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic reset_for(input int k, input logic [12:0] v);
    rst   = 1'b1;
    value = v;
    repeat (k) tick();
    rst  = 1'b0;
    base = cyc_free;
  endtask

  task automatic wait_update(input string name, input int exp_n);
    int seen;
    seen = -1;
    while (n_now() < exp_n + 3) begin
      tick();
      if (update === 1'b1) begin
        seen = n_now();
        break;
      end
    end
    check(name, seen, exp_n);
  endtask

  task automatic check_display(input string name, input vec_t v, input int ncyc);
    int k;
    for (int i = 0; i < ncyc; i++) begin
      tick();
      case (anode)
        4'b1110: k = 0;
        4'b1101: k = 1;
        4'b1011: k = 2;
        4'b0111: k = 3;
        default: k = -1;
      endcase
      if (k < 0) begin
        checks++;
        failures++;
        $display("FAIL %s anode: got %b expected one-hot-low", name, anode);
      end else begin
        check($sformatf("%s val=%0d digit%0d", name, v.val, k), segments, v.segs[k]);
      end
    end
  endtask

  initial begin
    vecs[0] = '{13'd1234, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}};
    vecs[1] = '{13'd8191, {7'b0000000, 7'b1111001, 7'b0010000, 7'b1111001}};
    vecs[2] = '{13'd0,    {BL, BL, BL, 7'b1000000}};
    vecs[3] = '{13'd42,   {BL, BL, 7'b0011001, 7'b0100100}};
    vecs[4] = '{13'd1005, {7'b1111001, 7'b1000000, 7'b1000000, 7'b0010010}};
    vecs[5] = '{13'd70,   {BL, BL, 7'b1111000, 7'b1000000}};
    vecs[6] = '{13'd6,    {BL, BL, BL, 7'b0000010}};
    vecs[7] = '{13'd999,  {BL, 9'd0 == 0 ? 7'b0010000 : BL, 7'b0010000, 7'b0010000}};

    // Reset for 3 cycles, then watch 20 cycles of scan with value 0.
    rst   = 1'b1;
    value = 13'd0;
    tick();
    check("rst anode", anode, 4'b1111);
    check("rst segments", segments, 7'b1111111);
    check("rst update", update, 1'b0);
    tick();
    tick();
    rst  = 1'b0;
    base = cyc_free;
    for (int n = 1; n <= 20; n++) begin
      logic [3:0] ea;
      int         d;
      tick();
      d  = ((n - 1) / 4) % 4;
      ea = ~(4'b0001 << d);
      check($sformatf("scan anode n=%0d", n), anode, ea);
      check($sformatf("scan seg n=%0d", n), segments, (d == 0) ? 7'b1000000 : BL);
      check($sformatf("scan update n=%0d", n), update, (n == 14));
    end

    // Table of values: pulse timing and a full 16-cycle scan of every digit.
    for (int i = 0; i < 8; i++) begin
      reset_for(2, vecs[i].val);
      wait_update($sformatf("update latency val=%0d", vecs[i].val), 14);
      tick();
      check_display("table", vecs[i], 16);
    end

    // Input change during SHIFT is ignored until the next IDLE.
    reset_for(2, 13'd1234);
    repeat (5) tick();
    value = 13'd42;
    wait_update("midchange update1", 14);
    tick();
    check_display("midchange first", vecs[0], 13);
    wait_update("midchange update2", 29);
    tick();
    check_display("midchange second", vecs[3], 16);

    // Reset on the 7th SHIFT cycle aborts the conversion in flight.
    reset_for(2, 13'd1234);
    wait_update("abort pre update", 14);
    tick();
    check_display("abort pre", vecs[0], 6);
    tick();
    rst = 1'b1;
    tick();
    check("abort rst anode", anode, 4'b1111);
    check("abort rst segments", segments, 7'b1111111);
    check("abort rst update", update, 1'b0);
    rst  = 1'b0;
    base = cyc_free;
    check_display("abort zero", vecs[2], 13);
    wait_update("abort next update", 14);
    tick();
    check_display("abort post", vecs[0], 16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
